cpu_datapath: RTL and testbench

- Bus-based datapath of the basic CPU; sits directly downstream of the control unit and consumes its one-hot register strobes and ALU controls.
- Holds IR, R0–R7, accumulator A and result register G.
- Drives a single shared bus, computes A ± bus, and returns IR to the control unit for decode.
- IR format: IR[8:6] opcode, IR[5:3] rX, IR[2:0] rY.

---
 rtl/cpu_datapath.sv | 125 ++++++++++++
 tb/tb_cpu_datapath.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// cpu_datapath: bus-based datapath of the basic CPU (IR, R0-R7, A, G, shared bus, add/sub ALU).
// Condition flags flag_z/flag_c are built only when BASIC_CPU_FLAGS_EN is defined.
module cpu_datapath #(
  parameter int DATA_W = 9
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] DIN,
  input  logic              IRin,
  input  logic              DINout,
  input  logic              Gout,
  input  logic [7:0]        Rout,
  input  logic [7:0]        Rin,
  input  logic              Ain,
  input  logic              Gin,
  input  logic              AddSub,
  output logic [8:0]        IR,
  output logic [DATA_W-1:0] BusWires,
  input  logic [2:0]        rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              bus_err,
  output logic              flag_z,
  output logic              flag_c
);

  logic [DATA_W-1:0] regs_r [8];
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] g_r;
  logic [DATA_W-1:0] bus_s;
  logic [8:0]        ir_r;
  logic              err_r;
  logic [9:0]        src_s;
  logic              multi_s;
  logic [DATA_W:0]   alu_s;

  // Fixed-priority bus mux: DINout > Gout > Rout[0] > ... > Rout[7]; idle bus reads 0.
  always_comb begin
    bus_s = {DATA_W{1'b0}};
    if (DINout) begin
      bus_s = DIN;
    end else if (Gout) begin
      bus_s = g_r;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (Rout[i]) begin
          bus_s = regs_r[i];
        end else begin
          bus_s = bus_s;
        end
      end
    end
  end

  // More than one bus driver: clearing the lowest set bit leaves something behind.
  assign src_s   = {DINout, Gout, Rout};
  assign multi_s = |(src_s & (src_s - 10'd1));

  // Extended-width ALU; the top bit is carry for add and borrow for subtract.
  always_comb begin
    if (AddSub) begin
      alu_s = {1'b0, a_r} - {1'b0, bus_s};
    end else begin
      alu_s = {1'b0, a_r} + {1'b0, bus_s};
    end
  end

  // Architectural state; every strobe is obeyed on every edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      a_r   <= {DATA_W{1'b0}};
      g_r   <= {DATA_W{1'b0}};
      ir_r  <= 9'd0;
      err_r <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (Rin[i]) begin
          regs_r[i] <= bus_s;
        end
      end
      if (IRin) begin
        ir_r <= DIN[8:0];
      end
      if (Ain) begin
        a_r <= bus_s;
      end
      if (Gin) begin
        g_r <= alu_s[DATA_W-1:0];
      end
      if (multi_s) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef BASIC_CPU_FLAGS_EN
  logic z_r;
  logic c_r;

  // Flags track the most recent G capture and hold otherwise.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      z_r <= 1'b0;
      c_r <= 1'b0;
    end else if (Gin) begin
      z_r <= (alu_s[DATA_W-1:0] == {DATA_W{1'b0}});
      c_r <= alu_s[DATA_W];
    end
  end

  assign flag_z = z_r;
  assign flag_c = c_r;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

  assign IR       = ir_r;
  assign BusWires = bus_s;
  assign rd_data  = regs_r[rd_sel];
  assign bus_err  = err_r;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed cases with literal expectations,
// then randomized strobes checked against a behavioural model of the datapath.
module tb_cpu_datapath;
  localparam int W = 9;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] din = '0;
  logic         irin = 1'b0, dinout = 1'b0, gout = 1'b0;
  logic [7:0]   rout = 8'd0, rin = 8'd0;
  logic         ain = 1'b0, gin = 1'b0, addsub = 1'b0;
  logic [8:0]   ir;
  logic [W-1:0] bus_wires;
  logic [2:0]   rd_sel = 3'd0;
  logic [W-1:0] rd_data;
  logic         bus_err, flag_z, flag_c;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the architectural state
  logic [W-1:0] m_r [8];
  logic [W-1:0] m_a, m_g;
  logic [8:0]   m_ir;
  logic         m_err, m_z, m_c;

  cpu_datapath #(.DATA_W(W)) dut (
    .clock(clock), .resetn(resetn), .DIN(din), .IRin(irin), .DINout(dinout),
    .Gout(gout), .Rout(rout), .Rin(rin), .Ain(ain), .Gin(gin), .AddSub(addsub),
    .IR(ir), .BusWires(bus_wires), .rd_sel(rd_sel), .rd_data(rd_data),
    .bus_err(bus_err), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #20 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_bus();
    if (dinout) return din;
    if (gout) return m_g;
    for (int i = 0; i < 8; i++) if (rout[i]) return m_r[i];
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_a = '0; m_g = '0; m_ir = '0; m_err = 1'b0; m_z = 1'b0; m_c = 1'b0;
  endtask

  task automatic model_edge();
    int av, bv, full, res;
    logic [W-1:0] b;
    b = model_bus();
    av = int'(m_a);
    bv = int'(b);
    full = addsub ? (av - bv) : (av + bv);
    res = (full + 2 * (1 << W)) % (1 << W);
    if (gin) begin
      m_g = res[W-1:0];
`ifdef BASIC_CPU_FLAGS_EN
      m_z = (res == 0);
      m_c = addsub ? (av < bv) : (full >= (1 << W));
`endif
    end
    if (ain) m_a = b;
    for (int i = 0; i < 8; i++) if (rin[i]) m_r[i] = b;
    if (irin) m_ir = din[8:0];
    if ($countones({dinout, gout, rout}) > 1) m_err = 1'b1;
  endtask

  task automatic drv(input logic [W-1:0] d, input logic i_l, input logic dout, input logic go,
                     input logic [7:0] ro, input logic [7:0] ri, input logic a, input logic g,
                     input logic s);
    din = d; irin = i_l; dinout = dout; gout = go; rout = ro; rin = ri;
    ain = a; gin = g; addsub = s; rd_sel = 3'($urandom_range(0, 7));
  endtask

  // Reads G through the bus without disturbing any state (no edge in between).
  task automatic peek_g(input string name, input logic [W-1:0] exp);
    logic sd, sg;
    sd = dinout; sg = gout;
    dinout = 1'b0; gout = 1'b1;
    #1 chk(name, bus_wires, exp);
    dinout = sd; gout = sg;
  endtask

  task automatic peek_r(input string name, input int k, input logic [W-1:0] exp);
    rd_sel = 3'(k);
    #1 chk(name, rd_data, exp);
  endtask

  task automatic check_all();
    chk("IR", ir, m_ir);
    chk("bus_err", bus_err, m_err);
    chk("flag_z", flag_z, m_z);
    chk("flag_c", flag_c, m_c);
    for (int k = 0; k < 8; k++) peek_r($sformatf("R%0d", k), k, m_r[k]);
    peek_g("G", m_g);
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic apply();
    #1;
    chk("BusWires", bus_wires, model_bus());
    chk("rd_data", rd_data, m_r[rd_sel]);
    @(posedge clock);
    model_edge();
    #1 check_all();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3;
    drv(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
        1'($urandom), 1'($urandom), 1'($urandom));
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst IR", ir, 9'd0);
    chk("rst bus_err", bus_err, 1'b0);
    chk("rst flag_z", flag_z, 1'b0);
    chk("rst flag_c", flag_c, 1'b0);
    for (int k = 0; k < 8; k++) peek_r($sformatf("rst R%0d", k), k, 9'd0);
    dinout = 1'b0;
    #1 chk("rst BusWires", bus_wires, 9'd0);
    peek_g("rst G", 9'd0);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    drv('0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #5 resetn = 1'b1;
    do_reset();

    // mvi R2, then IR load
    drv(9'h0A5, 0, 1, 0, 8'd0, 8'b0000_0100, 0, 0, 0); apply();
    peek_r("mvi R2", 2, 9'h0A5);
    peek_r("mvi R1 unchanged", 1, 9'h000);
    drv(9'h1C3, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0); apply();
    chk("IR load", ir, 9'h1C3);

    // add R1 = R1 + R2
    drv(9'd5, 0, 1, 0, 8'd0, 8'b0000_0010, 0, 0, 0); apply();
    drv(9'd7, 0, 1, 0, 8'd0, 8'b0000_0100, 0, 0, 0); apply();
    drv('0, 0, 0, 0, 8'b0000_0010, 8'd0, 1, 0, 0); apply();
    drv('0, 0, 0, 0, 8'b0000_0100, 8'd0, 0, 1, 0); apply();
    drv('0, 0, 0, 1, 8'd0, 8'b0000_0010, 0, 0, 0); apply();
    peek_r("add R1", 1, 9'd12);
    chk("add bus_err", bus_err, 1'b0);

    // subtract wrap and zero
    drv(9'd3, 0, 1, 0, 8'd0, 8'd0, 1, 0, 0); apply();
    drv(9'd5, 0, 1, 0, 8'd0, 8'd0, 0, 1, 1); apply();
    peek_g("sub wrap G", 9'h1FE);
`ifdef BASIC_CPU_FLAGS_EN
    chk("sub wrap flag_c", flag_c, 1'b1);
    chk("sub wrap flag_z", flag_z, 1'b0);
`endif
    drv(9'd5, 0, 1, 0, 8'd0, 8'd0, 1, 0, 0); apply();
    drv(9'd5, 0, 1, 0, 8'd0, 8'd0, 0, 1, 1); apply();
    peek_g("sub zero G", 9'h000);
`ifdef BASIC_CPU_FLAGS_EN
    chk("sub zero flag_z", flag_z, 1'b1);
    chk("sub zero flag_c", flag_c, 1'b0);
`endif

    // Ain and Gin together: G uses old A
    drv(9'd2, 0, 1, 0, 8'd0, 8'd0, 1, 0, 0); apply();
    drv(9'd4, 0, 1, 0, 8'd0, 8'd0, 1, 1, 0); apply();
    peek_g("hazard G", 9'd6);
    drv(9'd0, 0, 1, 0, 8'd0, 8'd0, 0, 1, 0); apply();
    peek_g("hazard new A", 9'd4);

    // Contention: DIN wins, bus_err is sticky
    drv(9'h022, 0, 1, 0, 8'd0, 8'b0000_1000, 0, 0, 0); apply();
    drv(9'h011, 0, 1, 0, 8'b0000_1000, 8'b0001_0000, 0, 0, 0); apply();
    peek_r("contention R4", 4, 9'h011);
    chk("contention bus_err", bus_err, 1'b1);
    drv('0, 0, 0, 0, 8'd0, 8'd0, 0, 0, 0); apply();
    chk("bus_err sticky", bus_err, 1'b1);

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      logic [7:0] ro;
      if (n % 100 == 0) do_reset();
      case ($urandom_range(0, 3))
        0: ro = 8'd0;
        1: ro = 8'($urandom);
        default: ro = 8'd1 << $urandom_range(0, 7);
      endcase
      drv(W'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0), ro, 8'($urandom) & 8'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
      apply();
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
